cs_approx_avg: RTL and testbench



---
 rtl/cs_approx_avg.sv | 75 +++++++
 tb/tb_cs_approx_avg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cs_approx_avg.sv
// ---------------------------------------------------------------------------
// cs_approx_avg
//
// Streaming approximate-averaging filter. One 8-bit sample is taken on every
// rising clock edge into a 9-deep sliding window. From the window contents
// the block derives:
//   sum   = sum of all nine samples          (12 bits, max 2295)
//   avg   = floor(sum / 9)                    (0..255)
//   xappr = largest window sample <= avg
//   Y     = floor((sum + 9 * xappr) / 8)      (10 bits, max 573)
//
// Ports:
//   clk    input   1   system clock, rising-edge active
//   reset  input   1   synchronous active-high reset, clears the window
//   X      input   8   unsigned input sample
//   Y      output 10   unsigned filtered result, combinational from window
// ---------------------------------------------------------------------------
module cs_approx_avg (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] X,
  output logic [9:0] Y
);

  localparam int WinLen = 9;

  logic [7:0]  window [WinLen];
  logic [11:0] win_sum;
  logic [11:0] win_avg;
  logic [7:0]  x_appr;

  // Sample window: entry 0 holds the newest sample. It shifts on every
  // edge with no enable; reset wipes it so warm-up starts from zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < WinLen; k++) begin
        window[k] <= 8'd0;
      end
    end else begin
      for (int k = WinLen - 1; k > 0; k--) begin
        window[k] <= window[k-1];
      end
      window[0] <= X;
    end
  end

  // Window sum; 12 bits hold the worst case of nine 0xFF samples.
  always_comb begin
    win_sum = 12'd0;
    for (int k = 0; k < WinLen; k++) begin
      win_sum = win_sum + 12'(window[k]);
    end
  end

  // Exact integer floor division by the constant 9. The quotient is kept
  // at full width so the comparisons below see it without truncation.
  assign win_avg = win_sum / 12'd9;

  // Largest sample not above the average. The window minimum never exceeds
  // the average, so at least one entry always qualifies; starting from 0 is
  // therefore safe.
  always_comb begin
    x_appr = 8'd0;
    for (int k = 0; k < WinLen; k++) begin
      if ((12'(window[k]) <= win_avg) && (window[k] > x_appr)) begin
        x_appr = window[k];
      end
    end
  end

  // (sum + 9*xappr) peaks at 4590, so a 13-bit intermediate suffices; the
  // divide by 8 is a plain shift and the result always fits in 10 bits.
  assign Y = 10'((13'(win_sum) + 13'(x_appr) * 13'd9) >> 3);

endmodule

// File: tb/tb_cs_approx_avg.sv
// ---------------------------------------------------------------------------
// tb_cs_approx_avg
//
// Self-checking bench for cs_approx_avg. Inputs change after the falling
// edge, outputs are sampled 1 time unit after the rising edge. Expected
// values come either from the worked numbers for each directed scenario or
// from a plain-arithmetic reference model of the nine-sample window.
// ---------------------------------------------------------------------------
module tb_cs_approx_avg;

  logic       clk;
  logic       reset;
  logic [7:0] X;
  logic [9:0] Y;

  int errors;
  int checks;
  int model_win [9];
  int captured;

  cs_approx_avg dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed straight from the formula on the model window.
  function automatic int modelY();
    int total;
    int avg;
    int best;
    total = 0;
    for (int k = 0; k < 9; k++) total += model_win[k];
    avg  = total / 9;
    best = -1;
    for (int k = 0; k < 9; k++) begin
      if (model_win[k] <= avg && model_win[k] > best) best = model_win[k];
    end
    return (total + 9 * best) / 8;
  endfunction

  // Drive one cycle: set inputs after the falling edge, let the rising edge
  // capture them, update the model to match, then wait 1 unit to sample.
  task automatic applyStimulus(input bit rst, input logic [7:0] sample);
    @(negedge clk);
    reset = rst;
    X     = sample;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 9; k++) model_win[k] = 0;
      captured = 0;
    end else begin
      for (int k = 8; k > 0; k--) model_win[k] = model_win[k-1];
      model_win[0] = int'(sample);
      captured++;
    end
    #1;
  endtask

  // Compare Y against a fixed expected value.
  task automatic checkOutput(input string tag, input int expected);
    checks++;
    assert (Y === 10'(expected)) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, Y, expected);
    end
  endtask

  initial begin
    int rnd_checks;
    errors   = 0;
    checks   = 0;
    captured = 0;
    for (int k = 0; k < 9; k++) model_win[k] = 0;
    reset = 1'b1;
    X     = 8'hFF;

    // Reset held with 0xFF on the input must read zero.
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("reset_hold", 0);

    // First sample 9 into an all-zero window.
    applyStimulus(1'b0, 8'h09);
    checkOutput("first_sample", 1);

    // Constant stream of 5s, steady once the window is full.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 8'd5);
      if (i >= 8) checkOutput("const_5", 11);
    end

    // Ramp 1..9 then 10.
    for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 8'(i));
    checkOutput("ramp_1_9", 11);
    applyStimulus(1'b0, 8'd10);
    checkOutput("ramp_2_10", 13);

    // Outlier above the average must be excluded from xappr.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b0, 8'd90);
    checkOutput("outlier", 11);

    // Full-scale window.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'hFF);
      if (i >= 8) checkOutput("max_range", 573);
    end

    // Mid-stream reset after a full 0xFF window.
    applyStimulus(1'b1, 8'hFF);
    checkOutput("mid_reset", 0);
    applyStimulus(1'b0, 8'h10);
    checkOutput("post_reset", 2);

    // Warm-up values against the model, including leftover zeros.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 8'($urandom_range(0, 255)));
      checkOutput("warmup_model", modelY());
    end

    // Random regression from a clean reset, checked from the 9th sample on.
    applyStimulus(1'b1, 8'h00);
    rnd_checks = 0;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'b0, 8'($urandom));
      if (captured >= 9) begin
        checkOutput("random_model", modelY());
        rnd_checks++;
      end
    end

    // Random samples biased to the extremes to stress xappr selection.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255))
                                                      : 8'($urandom_range(0, 15)));
      checkOutput("extreme_model", modelY());
    end

    $display("[TB] random comparisons: %0d", rnd_checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
